// File: rtl/dmi_req_arb_if.sv
// Channel bundle for dmi_req_arb: two requester request/response pairs plus the
// request/response pair towards the debug module. "slave" is the arbiter's view.
interface dmi_req_arb_if #(
    parameter int TX_WIDTH = 41,
    parameter int RX_WIDTH = 34
);
    logic                r0_req_vld;
    logic [TX_WIDTH-1:0] r0_req_data;
    logic                r0_req_rdy;
    logic                r0_resp_vld;
    logic [RX_WIDTH-1:0] r0_resp_data;
    logic                r0_resp_rdy;

    logic                r1_req_vld;
    logic [TX_WIDTH-1:0] r1_req_data;
    logic                r1_req_rdy;
    logic                r1_resp_vld;
    logic [RX_WIDTH-1:0] r1_resp_data;
    logic                r1_resp_rdy;

    logic                dreq_vld;
    logic [TX_WIDTH-1:0] dreq_data;
    logic                dreq_rdy;
    logic                dresp_vld;
    logic [RX_WIDTH-1:0] dresp_data;
    logic                dresp_rdy;

    modport slave (
        input  r0_req_vld, r0_req_data, r0_resp_rdy,
        output r0_req_rdy, r0_resp_vld, r0_resp_data,
        input  r1_req_vld, r1_req_data, r1_resp_rdy,
        output r1_req_rdy, r1_resp_vld, r1_resp_data,
        output dreq_vld, dreq_data, dresp_rdy,
        input  dreq_rdy, dresp_vld, dresp_data
    );

    modport master (
        output r0_req_vld, r0_req_data, r0_resp_rdy,
        input  r0_req_rdy, r0_resp_vld, r0_resp_data,
        output r1_req_vld, r1_req_data, r1_resp_rdy,
        input  r1_req_rdy, r1_resp_vld, r1_resp_data,
        input  dreq_vld, dreq_data, dresp_rdy,
        output dreq_rdy, dresp_vld, dresp_data
    );
endinterface

// File: rtl/dmi_req_arb.sv
// Two-requester DMI arbiter: one outstanding transaction, alternating tie-break,
// response timeout with a saturating error counter.
module dmi_req_arb #(
    parameter int TX_WIDTH = 41,
    parameter int RX_WIDTH = 34,
    parameter int TIMEOUT  = 255
) (
    input  logic         cclk,
    input  logic         dev_rst_n,
    dmi_req_arb_if.slave bus,
    output logic         busy,
    output logic [7:0]   err_cnt
);
    localparam int                  NREQ     = 2;
    localparam logic [7:0]          TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [RX_WIDTH-1:0] TMO_RESP = RX_WIDTH'(2'b10);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_RET} state_e;

    state_e                        state_q, state_d, st_eff;
    logic                          last_gnt_q, last_gnt_d;
    logic                          gnt_q, gnt_d;
    logic [7:0]                    timer_q, timer_d;
    logic [7:0]                    err_cnt_q, err_cnt_d;
    logic                          dreq_vld_q, dreq_vld_d;
    logic [TX_WIDTH-1:0]           dreq_data_q, dreq_data_d;
    logic [NREQ-1:0]               resp_vld_q, resp_vld_d;
    logic [NREQ-1:0][RX_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [NREQ-1:0]               req_vld, req_rdy, resp_rdy;
    logic [NREQ-1:0][TX_WIDTH-1:0] req_data;
    logic                          lg_eff, winner;
    logic                          req_hs, dreq_hs, dresp_rdy, dresp_hs, resp_hs;
    logic                          tmo, tmo_fire;

    assign req_vld  = {bus.r1_req_vld,  bus.r0_req_vld};
    assign req_data = {bus.r1_req_data, bus.r0_req_data};
    assign resp_rdy = {bus.r1_resp_rdy, bus.r0_resp_rdy};

    assign bus.r0_req_rdy   = req_rdy[0];
    assign bus.r1_req_rdy   = req_rdy[1];
    assign bus.r0_resp_vld  = resp_vld_q[0];
    assign bus.r1_resp_vld  = resp_vld_q[1];
    assign bus.r0_resp_data = resp_data_q[0];
    assign bus.r1_resp_data = resp_data_q[1];
    assign bus.dreq_vld     = dreq_vld_q;
    assign bus.dreq_data    = dreq_data_q;
    assign bus.dresp_rdy    = dresp_rdy;

    // While reset is held the handshake outputs already look like IDLE, even
    // before the first edge has cleared the registers.
    assign st_eff = dev_rst_n ? state_q : S_IDLE;
    assign lg_eff = dev_rst_n ? last_gnt_q : 1'b1;

    always_comb begin
        case (req_vld)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~lg_eff;
        endcase
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_rdy
        assign req_rdy[i] = (st_eff == S_IDLE) && (winner == 1'(i));
    end

    assign req_hs    = |(req_vld & req_rdy);
    assign dreq_hs   = dreq_vld_q & bus.dreq_rdy;
    assign dresp_rdy = (st_eff != S_REQ);
    assign dresp_hs  = bus.dresp_vld & dresp_rdy;
    assign resp_hs   = resp_vld_q[gnt_q] & resp_rdy[gnt_q];
    assign tmo       = (timer_q == TMO_LAST);
    // A handshake landing on the last timer cycle wins over the timeout.
    assign tmo_fire  = tmo && (((state_q == S_REQ)  && !dreq_hs) ||
                               ((state_q == S_RESP) && !dresp_hs));

    assign busy    = (st_eff != S_IDLE);
    assign err_cnt = err_cnt_q;

    always_ff @(posedge cclk) begin
        if (!dev_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_hs) state_d = S_REQ;
            S_REQ:   if (dreq_hs) state_d = S_RESP;
                     else if (tmo_fire) state_d = S_RET;
            S_RESP:  if (dresp_hs || tmo_fire) state_d = S_RET;
            S_RET:   if (resp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        timer_d     = timer_q;
        err_cnt_d   = err_cnt_q;
        dreq_vld_d  = dreq_vld_q;
        dreq_data_d = dreq_data_q;
        resp_vld_d  = resp_vld_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    dreq_data_d = req_data[winner];
                    dreq_vld_d  = 1'b1;
                    gnt_d       = winner;
                    last_gnt_d  = winner;
                    timer_d     = 8'd0;
                end
            end
            S_REQ: begin
                timer_d = timer_q + 8'd1;
                if (dreq_hs) begin
                    dreq_vld_d = 1'b0;
                    timer_d    = 8'd0;
                end
            end
            S_RESP: begin
                timer_d = timer_q + 8'd1;
                if (dresp_hs) begin
                    resp_data_d[gnt_q] = bus.dresp_data;
                    resp_vld_d[gnt_q]  = 1'b1;
                end
            end
            S_RET: begin
                if (resp_hs) resp_vld_d[gnt_q] = 1'b0;
            end
            default: ;
        endcase
        if (tmo_fire) begin
            dreq_vld_d         = 1'b0;
            resp_data_d[gnt_q] = TMO_RESP;
            resp_vld_d[gnt_q]  = 1'b1;
            err_cnt_d          = err_cnt_q + {7'd0, (err_cnt_q != 8'hFF)};
        end
    end

    always_ff @(posedge cclk) begin
        if (!dev_rst_n) begin
            last_gnt_q  <= 1'b1;
            gnt_q       <= 1'b0;
            timer_q     <= 8'd0;
            err_cnt_q   <= 8'd0;
            dreq_vld_q  <= 1'b0;
            dreq_data_q <= '0;
            resp_vld_q  <= '0;
            resp_data_q <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            timer_q     <= timer_d;
            err_cnt_q   <= err_cnt_d;
            dreq_vld_q  <= dreq_vld_d;
            dreq_data_q <= dreq_data_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
        end
    end
endmodule

// File: doc/dmi_req_arb.md
DMI_REQ_ARB -- requirements
Module: dmi_req_arb

Interface
REQ-001 Parameter TX_WIDTH, default 41, SHALL be the request width: {addr[7], data[32], op[2]}.
REQ-002 Parameter RX_WIDTH, default 34, SHALL be the response width: {data[32], op[2]}.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the response timeout in cycles (range 1..255, 8-bit timer).
REQ-004 cclk  in  1  SHALL be the single core clock; all logic is on its rising edge.
REQ-005 dev_rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-006 r0_req_vld / r0_req_data / r0_req_rdy  in / in / out  1 / TX_WIDTH / 1  SHALL form the requester-0 request channel.
REQ-007 r0_resp_vld / r0_resp_data / r0_resp_rdy  out / out / in  1 / RX_WIDTH / 1  SHALL form the requester-0 response channel.
REQ-008 r1_req_* and r1_resp_* SHALL mirror REQ-006 and REQ-007 for requester 1.
REQ-009 dreq_vld / dreq_data / dreq_rdy  out / out / in  1 / TX_WIDTH / 1  SHALL form the request channel to the debug module.
REQ-010 dresp_vld / dresp_data / dresp_rdy  in / in / out  1 / RX_WIDTH / 1  SHALL form the response channel from the debug module.
REQ-011 busy  out  1  SHALL be high whenever state != IDLE.
REQ-012 err_cnt  out  8  SHALL count timeouts, saturating at 8'hFF.

Function
REQ-013 The FSM SHALL have four states: IDLE, REQ, RESP and RET. At most one transaction SHALL be outstanding.
REQ-014 Every channel transfer SHALL occur on a cycle where vld & rdy are both high.
REQ-015 In IDLE the winner SHALL be chosen as follows:
- Only one requester valid: that requester wins.
- Both valid: the requester other than last_gnt wins.
REQ-016 ri_req_rdy SHALL be combinational: (state==IDLE) & (winner==i). The loser SHALL see rdy=0.
REQ-017 On the IDLE request handshake, at the next edge:
- dreq_data <= ri_req_data; dreq_vld <= 1.
- gnt <= i; last_gnt <= i; timer <= 0.
- state -> REQ.
REQ-018 In REQ, on dreq handshake: dreq_vld <= 0, timer <= 0, state -> RESP. dreq_data SHALL hold stable until accepted.
REQ-019 dresp_rdy SHALL be combinational: state != REQ.
REQ-020 In RESP, on dresp handshake, at the next edge:
- r[gnt]_resp_data <= dresp_data; r[gnt]_resp_vld <= 1.
- state -> RET.
REQ-021 A dresp handshake in IDLE or RET SHALL be a stray response: discarded, with no change to any output.
REQ-022 The timer SHALL increment each cycle in REQ and RESP.
REQ-023 If the timer equals TIMEOUT-1 and no handshake occurs that cycle, at the next edge:
- dreq_vld <= 0.
- r[gnt]_resp_data <= {32'h0, 2'b10}; r[gnt]_resp_vld <= 1.
- err_cnt increments (saturating).
- state -> RET.
REQ-024 If a handshake and the timeout occur in the same cycle, the handshake SHALL take priority and no error is counted.
REQ-025 In RET, on r[gnt]_resp handshake: r[gnt]_resp_vld <= 0, state -> IDLE. A new grant is possible one cycle later at the earliest.
REQ-026 The resp_vld of the non-granted requester SHALL stay 0 at all times.
REQ-027 resp_data SHALL hold stable while resp_vld=1.

Reset
REQ-028 With dev_rst_n=0 at a cclk edge, the block SHALL reset to:
- state=IDLE, last_gnt=1 (requester 0 wins first tie).
- timer=0, err_cnt=0.
- dreq_vld=0, dreq_data=0, r0/r1_resp_vld=0, r0/r1_resp_data=0.
REQ-029 A reset mid-transaction SHALL abandon the transaction; no response is delivered to the requester. While reset is asserted, busy, ri_req_rdy and dresp_rdy SHALL follow the IDLE definitions.

Verification
REQ-030 Single request: r0 sends {7'h10, 32'h0, 2'b01}; debug module accepts and returns {32'h12345678, 2'b00} -> r0 receives exactly that data; r1_resp_vld stays 0; err_cnt=0.
REQ-031 Simultaneous requests: r0 and r1 both valid for 4 back-to-back transactions -> grant order r0, r1, r0, r1; each response goes to its originator.
REQ-032 Timeout: TIMEOUT=8; dresp_vld held 0 -> after 8 cycles in REQ+RESP, the granted requester gets {32'h0, 2'b10}; err_cnt=1; a following normal transaction succeeds.
REQ-033 Same-cycle race: dresp_vld asserted in the cycle where timer=TIMEOUT-1 -> real data is delivered; err_cnt unchanged.
REQ-034 Stray and backpressure: dresp_vld pulsed in IDLE -> no output change. Then r1_resp_rdy held 0 for 5 cycles in RET -> r1_resp_vld and r1_resp_data stay stable; r0_req_rdy stays 0.
REQ-035 Reset mid-transaction: dev_rst_n=0 for 1 cycle while in RESP -> all outputs return to the REQ-028 values; the next tie grants r0.
